// File: rtl/wb_byte_master_pkg.sv
// Shared constants and types for the byte-stream Wishbone initiator.
package wb_byte_master_pkg;

   // Command opcodes accepted on the byte stream
   localparam logic [7:0] OP_WRITE    = 8'h57;
   localparam logic [7:0] OP_READ     = 8'h52;

   // Status bytes returned on the response stream
   localparam logic [7:0] RSP_OK      = 8'h4B;
   localparam logic [7:0] RSP_TIMEOUT = 8'h54;
   localparam logic [7:0] RSP_BADOP   = 8'h3F;

   // Longest response: status byte plus four read-data bytes
   localparam int RESP_BYTES = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_BUS,
      ST_RESP
   } state_t;

endpackage

// File: rtl/wb_byte_master_if.sv
// Byte-stream transport plus Wishbone classic initiator signals.
interface wb_byte_master_if;

   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;

   // Seen from the command parser / bus initiator
   modport master (
      input  rx_data, rx_valid, tx_ready, wbm_dat_i, wbm_ack_i,
      output rx_ready, tx_data, tx_valid,
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
   );

   // Seen from the byte transport and the Wishbone slave
   modport slave (
      output rx_data, rx_valid, tx_ready, wbm_dat_i, wbm_ack_i,
      input  rx_ready, tx_data, tx_valid,
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
   );

endinterface

// File: rtl/wb_byte_master.sv
// Parses 'W'/'R' command frames from a byte stream, runs one Wishbone
// classic cycle per frame and streams back a status byte (plus read data).
module wb_byte_master
   import wb_byte_master_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   wb_byte_master_if.master bus,
   output logic             busy
);

   state_t      state_reg, state_next;
   logic [1:0]  byte_cnt_reg, byte_cnt_next;
   logic        we_reg, we_next;
   logic [31:0] adr_reg, adr_next;
   logic [31:0] dat_reg, dat_next;
   logic [15:0] tmo_reg, tmo_next;
   // Response bytes go out from bits [7:0]; the buffer shifts right per byte
   logic [8*RESP_BYTES-1:0] resp_reg, resp_next;
   logic [2:0]  resp_cnt_reg, resp_cnt_next;

   logic        accepting;
   logic        rx_fire;

   assign accepting = (state_reg == ST_IDLE) || (state_reg == ST_ADDR) ||
                      (state_reg == ST_DATA);
   assign rx_fire   = bus.rx_valid && accepting;

   // Host stalls whenever the block is in reset or not collecting a frame
   assign bus.rx_ready  = accepting && !wb_rst_i;
   assign bus.tx_valid  = (state_reg == ST_RESP);
   assign bus.tx_data   = resp_reg[7:0];
   assign bus.wbm_cyc_o = (state_reg == ST_BUS);
   assign bus.wbm_stb_o = (state_reg == ST_BUS);
   assign bus.wbm_sel_o = (state_reg == ST_BUS) ? 4'hF : 4'h0;
   assign bus.wbm_we_o  = we_reg;
   assign bus.wbm_adr_o = adr_reg;
   assign bus.wbm_dat_o = dat_reg;
   assign busy          = (state_reg != ST_IDLE);

   // Next-state and datapath update for frame parsing, bus cycle and response
   always_comb begin
      state_next    = state_reg;
      byte_cnt_next = byte_cnt_reg;
      we_next       = we_reg;
      adr_next      = adr_reg;
      dat_next      = dat_reg;
      tmo_next      = tmo_reg;
      resp_next     = resp_reg;
      resp_cnt_next = resp_cnt_reg;

      case (state_reg)
         ST_IDLE: begin
            if (rx_fire) begin
               if (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ) begin
                  we_next       = (bus.rx_data == OP_WRITE);
                  byte_cnt_next = 2'd0;
                  state_next    = ST_ADDR;
               end else begin
                  resp_next     = {32'h0, RSP_BADOP};
                  resp_cnt_next = 3'd1;
                  state_next    = ST_RESP;
               end
            end
         end

         ST_ADDR: begin
            if (rx_fire) begin
               // Little-endian: first byte ends up in adr[7:0]
               adr_next      = {bus.rx_data, adr_reg[31:8]};
               byte_cnt_next = byte_cnt_reg + 2'd1;
               if (byte_cnt_reg == 2'd3) begin
                  tmo_next   = 16'd0;
                  state_next = we_reg ? ST_DATA : ST_BUS;
               end
            end
         end

         ST_DATA: begin
            if (rx_fire) begin
               dat_next      = {bus.rx_data, dat_reg[31:8]};
               byte_cnt_next = byte_cnt_reg + 2'd1;
               if (byte_cnt_reg == 2'd3) begin
                  tmo_next   = 16'd0;
                  state_next = ST_BUS;
               end
            end
         end

         ST_BUS: begin
            // Acknowledge takes priority over a timeout in the same cycle
            if (bus.wbm_ack_i) begin
               if (we_reg) begin
                  resp_next     = {32'h0, RSP_OK};
                  resp_cnt_next = 3'd1;
               end else begin
                  resp_next     = {bus.wbm_dat_i, RSP_OK};
                  resp_cnt_next = 3'(RESP_BYTES);
               end
               state_next = ST_RESP;
            end else if (tmo_reg == 16'(TIMEOUT - 1)) begin
               resp_next     = {32'h0, RSP_TIMEOUT};
               resp_cnt_next = 3'd1;
               state_next    = ST_RESP;
            end else begin
               tmo_next = tmo_reg + 16'd1;
            end
         end

         ST_RESP: begin
            if (bus.tx_ready) begin
               resp_next     = {8'h0, resp_reg[8*RESP_BYTES-1:8]};
               resp_cnt_next = resp_cnt_reg - 3'd1;
               if (resp_cnt_reg == 3'd1) begin
                  state_next = ST_IDLE;
               end
            end
         end

         default: state_next = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any partial frame or cycle
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_reg    <= ST_IDLE;
         byte_cnt_reg <= 2'd0;
         we_reg       <= 1'b0;
         adr_reg      <= 32'h0;
         dat_reg      <= 32'h0;
         tmo_reg      <= 16'd0;
         resp_reg     <= '0;
         resp_cnt_reg <= 3'd0;
      end else begin
         state_reg    <= state_next;
         byte_cnt_reg <= byte_cnt_next;
         we_reg       <= we_next;
         adr_reg      <= adr_next;
         dat_reg      <= dat_next;
         tmo_reg      <= tmo_next;
         resp_reg     <= resp_next;
         resp_cnt_reg <= resp_cnt_next;
      end
   end

endmodule

// File: doc/wb_byte_master.md
# wb_byte_master

Byte-stream-driven Wishbone classic initiator: parses a simple command protocol arriving one byte at a time and issues single 32-bit read/write cycles toward the design's Wishbone slave (the multiplexer's configuration registers), letting an off-chip host configure the design without the management SoC. It sits between a byte transport (UART/SPI receiver and transmitter) and the wishbone port of the multiplexer. It returns a status byte, plus read data, on a byte output stream.

## Interface
- TIMEOUT, 255 — max cycles to wait for `wbm_ack_i` before abandoning a cycle; range 1..65535.
- wb_clk_i  in  1  sole clock, all logic rising-edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- rx_data  in  8  incoming command byte.
- rx_valid  in  1  `rx_data` valid.
- rx_ready  out  1  block accepts byte; transfer when valid&ready.
- tx_data  out  8  outgoing response byte.
- tx_valid  out  1  `tx_data` valid.
- tx_ready  in  1  sink accepts byte; transfer when valid&ready.
- wbm_cyc_o, wbm_stb_o  out  1 each  Wishbone cycle/strobe, always equal.
- wbm_we_o  out  1  1 = write.
- wbm_sel_o  out  4  byte select, always 4'hF during a cycle.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  slave acknowledge.
- busy  out  1  high in every state except IDLE.

## Operation
- Frames: write = 0x57 'W', A0..A3, D0..D3; read = 0x52 'R', A0..A3. Multi-byte fields little-endian (A0 = adr[7:0]).
- Responses: write OK -> 0x4B 'K'; read OK -> 0x4B then D0..D3 (dat[7:0] first); timeout -> 0x54 'T' (no data even for read); unknown opcode -> 0x3F '?'.
- FSM states: IDLE, ADDR, DATA, BUS, RESP.
  - IDLE: rx_ready=1. 'W'/'R' -> ADDR, latch we, clear byte counter. Other byte -> RESP with single 0x3F.
  - ADDR: rx_ready=1; each accepted byte shifts into adr; after 4th -> DATA if write, else BUS.
  - DATA: rx_ready=1; 4 bytes into dat_o; after 4th -> BUS.
  - BUS: rx_ready=0; cyc=stb=1; on ack: latch wbm_dat_i if read, -> RESP. Timeout counter expiring -> RESP with 0x54.
  - RESP: rx_ready=0; present bytes in order, each held stable until tx_ready; after last byte accepted -> IDLE.
- Bytes on rx are never dropped: rx_ready=0 outside IDLE/ADDR/DATA, so the host stalls.
- ack outside BUS is ignored. ack and timeout expiry in the same cycle: ack wins.
- wbm_adr_o/wbm_dat_o/wbm_we_o hold last values outside BUS (no glitch requirement on slave side beyond cyc).

## Timing
- Reset values: rx_ready=0 during reset cycle, 1 the cycle after; tx_valid=0, tx_data=0, cyc=stb=we=0, sel=0, adr=0, dat_o=0, busy=0; state IDLE; counters 0.
- cyc/stb rise the cycle after the last frame byte is accepted.
- ack sampled at edge N -> cyc/stb low at N+1, tx_valid high at N+1 with first response byte. No back-to-back cycles; minimum one idle cycle between cycles.
- Timeout: counter starts at 0 on BUS entry; if no ack by the TIMEOUT-th BUS cycle, cyc/stb drop next cycle, tx_valid rises same cycle.
- tx_valid at most one byte per cycle; with tx_ready tied high a read response takes 5 consecutive cycles.
- wb_rst_i mid-frame or mid-cycle: all state discarded, cyc/stb deasserted next edge, partial frame lost, no response emitted.

## Structure
- Shared package `wb_byte_master_pkg`: opcode constants (OP_WRITE 8'h57, OP_READ 8'h52), response codes (RSP_OK 8'h4B, RSP_TIMEOUT 8'h54, RSP_BADOP 8'h3F), state enum type.
- Single module; response path (5-byte shift register + remaining count) inline; no sub-module needed.

## Test plan
- Write 'W',78 56 34 12,EF BE AD DE, slave acks after 2 cycles -> one cycle, adr=0x12345678, dat_o=0xDEADBEEF, we=1, sel=F; response 0x4B.
- Read 'R',04 00 00 30, slave returns 0xCAFEF00D -> we=0, response 4B 0D F0 FE CA in order.
- No ack, TIMEOUT=8 -> cyc high exactly 8 cycles, response single 0x54.
- Opcode 0xAA -> no Wishbone cycle, response 0x3F, next 'R' frame processed normally.
- tx_ready low 10 cycles during read response, rx_valid held high with next frame -> tx_data stable, rx_ready=0 until response done, no bytes lost.
- Assert wb_rst_i during BUS with ack pending -> cyc=0 next cycle, tx_valid=0, busy=0, later ack ignored.
